// File: rtl/fp_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_seq_if
// Purpose  : Start/operand/result bundle between the core and fp_div_seq.
// Revision : 1.0
// ============================================================================
interface fp_div_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag_nv;
  logic        flag_dz;
  logic        flag_of;
  logic        flag_uf;
  logic        flag_nx;

  modport master (
    output start, a, b,
    input  busy, done, result, flag_nv, flag_dz, flag_of, flag_uf, flag_nx
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, flag_nv, flag_dz, flag_of, flag_uf, flag_nx
  );
endinterface
`default_nettype wire

// File: rtl/fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_seq
// Purpose  : Iterative FP32 divider, one quotient bit per cycle, RNE + flags.
// Revision : 1.0
// ============================================================================
module fp_div_seq (
  input wire          clk,
  input wire          reset,
  fp_div_seq_if.slave io_bus
);
  localparam int c_QBITS = 26;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic [24:0]        r_rem;
  logic [23:0]        r_mb;
  logic [25:0]        r_q;
  logic signed [9:0]  r_exp;
  logic               r_sign;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_result;
  logic               r_nv, r_dz, r_of, r_uf, r_nx;

  // Operand classification (subnormals flush to zero)
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_sign;
  logic        w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic        w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_ea     = io_bus.a[30:23];
  assign w_eb     = io_bus.b[30:23];
  assign w_fa     = io_bus.a[22:0];
  assign w_fb     = io_bus.b[22:0];
  assign w_sign   = io_bus.a[31] ^ io_bus.b[31];
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_a_snan = w_a_nan && !w_fa[22];
  assign w_b_snan = w_b_nan && !w_fb[22];
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);

  logic        w_special;
  logic [31:0] w_spec_res;
  logic        w_spec_nv;
  logic        w_spec_dz;

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = 32'h7FC0_0000;
    w_spec_nv  = 1'b0;
    w_spec_dz  = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_spec_nv = w_a_snan || w_b_snan;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_nv = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = {w_sign, 8'hFF, 23'd0};
    end else if (w_b_inf || w_a_zero) begin
      w_spec_res = {w_sign, 31'd0};
    end else if (w_b_zero) begin
      w_spec_res = {w_sign, 8'hFF, 23'd0};
      w_spec_dz  = 1'b1;
    end else begin
      w_special  = 1'b0;
    end
  end

  // Pre-normalise so the first quotient bit is always 1
  logic [23:0]       w_ma, w_mb;
  logic              w_ma_lt;
  logic signed [9:0] w_exp0;
  logic [24:0]       w_rem0;

  assign w_ma    = {1'b1, w_fa};
  assign w_mb    = {1'b1, w_fb};
  assign w_ma_lt = (w_ma < w_mb);
  assign w_exp0  = {2'b00, w_ea} - {2'b00, w_eb} + 10'd127 - {9'd0, w_ma_lt};
  assign w_rem0  = w_ma_lt ? {w_ma, 1'b0} : {1'b0, w_ma};

  logic        w_rem_ge;
  logic [24:0] w_rem_sub;

  assign w_rem_ge  = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_rem_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  logic              w_guard, w_round, w_sticky, w_inc, w_carry, w_inexact;
  logic [24:0]       w_mant_sum;
  logic [23:0]       w_mant;
  logic signed [9:0] w_exp_rnd;

  assign w_guard    = r_q[1];
  assign w_round    = r_q[0];
  assign w_sticky   = |r_rem;
  assign w_inc      = w_guard && (w_round || w_sticky || r_q[2]);
  assign w_mant_sum = {1'b0, r_q[25:2]} + {24'd0, w_inc};
  assign w_carry    = w_mant_sum[24];
  assign w_mant     = w_carry ? 24'h80_0000 : w_mant_sum[23:0];
  assign w_exp_rnd  = r_exp + {9'd0, w_carry};
  assign w_inexact  = w_guard || w_round || w_sticky;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_rem    <= 25'd0;
      r_mb     <= 24'd0;
      r_q      <= 26'd0;
      r_exp    <= 10'sd0;
      r_sign   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_nv     <= 1'b0;
      r_dz     <= 1'b0;
      r_of     <= 1'b0;
      r_uf     <= 1'b0;
      r_nx     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_busy <= 1'b1;
            r_nv   <= 1'b0;
            r_dz   <= 1'b0;
            r_of   <= 1'b0;
            r_uf   <= 1'b0;
            r_nx   <= 1'b0;
            if (w_special) begin
              r_result <= w_spec_res;
              r_nv     <= w_spec_nv;
              r_dz     <= w_spec_dz;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_rem   <= w_rem0;
              r_mb    <= w_mb;
              r_q     <= 26'd0;
              r_exp   <= w_exp0;
              r_sign  <= w_sign;
              r_cnt   <= 5'd0;
              r_state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_rem <= w_rem_sub << 1;
          r_q   <= {r_q[24:0], w_rem_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(c_QBITS - 1)) begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
          if (w_exp_rnd >= 10'sd255) begin
            r_result <= {r_sign, 8'hFF, 23'd0};
            r_of     <= 1'b1;
            r_nx     <= 1'b1;
          end else if (w_exp_rnd <= 10'sd0) begin
            r_result <= {r_sign, 31'd0};
            r_uf     <= 1'b1;
            r_nx     <= 1'b1;
          end else begin
            r_result <= {r_sign, w_exp_rnd[7:0], w_mant[22:0]};
            r_nx     <= w_inexact;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.result  = r_result;
  assign io_bus.flag_nv = r_nv;
  assign io_bus.flag_dz = r_dz;
  assign io_bus.flag_of = r_of;
  assign io_bus.flag_uf = r_uf;
  assign io_bus.flag_nx = r_nx;
endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_div_seq
// Purpose  : Self-checking bench for fp_div_seq against an exact-arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_fp_div_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_err = 0;
  int   n_chk = 0;

  fp_div_seq_if bus ();

  fp_div_seq dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact quotient via integer division; rounding decided by comparing 2*remainder to divisor
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f, output int lat);
    logic [7:0]      ea, eb;
    logic            s, an, bn, asn, bsn, ai, bi, az, bz;
    longint unsigned ma, mb, num, q, rm;
    int              e;
    ea  = a[30:23];
    eb  = b[30:23];
    s   = a[31] ^ b[31];
    an  = (ea == 8'hFF) && (a[22:0] != 0);
    bn  = (eb == 8'hFF) && (b[22:0] != 0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    ai  = (ea == 8'hFF) && (a[22:0] == 0);
    bi  = (eb == 8'hFF) && (b[22:0] == 0);
    az  = (ea == 0);
    bz  = (eb == 0);
    f   = 5'b0;
    lat = 1;
    if (an || bn) begin
      r = 32'h7FC00000; f[4] = asn || bsn;
    end else if ((az && bz) || (ai && bi)) begin
      r = 32'h7FC00000; f[4] = 1'b1;
    end else if (ai) begin
      r = {s, 8'hFF, 23'd0};
    end else if (bi || az) begin
      r = {s, 31'd0};
    end else if (bz) begin
      r = {s, 8'hFF, 23'd0}; f[3] = 1'b1;
    end else begin
      lat = 28;
      ma  = {40'd0, 1'b1, a[22:0]};
      mb  = {40'd0, 1'b1, b[22:0]};
      e   = int'(ea) - int'(eb) + 127;
      if (ma < mb) begin
        e--; num = ma << 24;
      end else begin
        num = ma << 23;
      end
      q  = num / mb;
      rm = num % mb;
      if ((2 * rm > mb) || ((2 * rm == mb) && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23; e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; f[2] = 1'b1; f[0] = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'd0}; f[1] = 1'b1; f[0] = 1'b1;
      end else begin
        r = {s, 8'(e), q[22:0]}; f[0] = (rm != 0);
      end
    end
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    int          sel;
    v   = $urandom;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       v[30:23] = 8'hFF;
      1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      2:       v[30:23] = 8'h00;
      3:       v[30:23] = 8'($urandom_range(1, 12));
      4:       v[30:23] = 8'($urandom_range(243, 254));
      5:       begin v[30:23] = 8'($urandom_range(100, 150)); v[22:0] = {3'($urandom_range(0, 7)), 20'd0}; end
      default: v[30:23] = 8'($urandom_range(90, 164));
    endcase
    return v;
  endfunction

  task automatic run_div(input logic [31:0] ta, input logic [31:0] tbv, input int poke, input string tag);
    logic [31:0] er;
    logic [4:0]  ef;
    int          elat, lat;
    logic        busy_ok;
    ref_div(ta, tbv, er, ef, elat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tbv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat       = 1;
    busy_ok   = 1'b1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.a     = 32'h3F800000;
        bus.b     = 32'h40400000;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
    end
    chk_eq({tag, " latency"}, lat, elat);
    chk_eq({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    chk_eq({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd1);
    chk_eq({tag, " result"}, bus.result, er);
    chk_eq({tag, " flags"}, {27'd0, bus.flag_nv, bus.flag_dz, bus.flag_of, bus.flag_uf, bus.flag_nx},
           {27'd0, ef});
    @(posedge clk);
    #1;
    chk_eq({tag, " done_drop"}, {30'd0, bus.done, bus.busy}, 32'd0);
    chk_eq({tag, " result_hold"}, bus.result, er);
  endtask

  logic [31:0] dir_a [12] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                              32'h00000000, 32'h7F800001, 32'h7FC00000, 32'h7F7FFFFF, 32'h00800000,
                              32'hFF800000, 32'h00400000};
  logic [31:0] dir_b [12] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000,
                              32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3E800000, 32'h40000000,
                              32'hFF800000, 32'h3F800000};

  initial begin
    int lat;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_state", {bus.result[31:0]}, 32'd0);
    chk_eq("reset_ctrl", {25'd0, bus.busy, bus.done, bus.flag_nv, bus.flag_dz, bus.flag_of,
                          bus.flag_uf, bus.flag_nx}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_div(dir_a[i], dir_b[i], 0, $sformatf("dir%0d", i));
    end

    run_div(32'h40C00000, 32'h40000000, 5, "busy_start");

    // Abort an operation with reset in cycle 10
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h40C00000;
    bus.b     = 32'h40000000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("abort_ctrl", {30'd0, bus.busy, bus.done}, 32'd0);
    chk_eq("abort_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_div(32'h3F800000, 32'h40400000, 0, "after_abort");

    for (int i = 0; i < 300; i++) begin
      run_div(rnd_fp(), rnd_fp(), 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
